// File: rtl/mul12u_dot_acc.sv
// Dot-product accumulator fed by the 12x12 unsigned multiplier.
// Sums up to LEN products per vector and hands off sum and term count.
module mul12u_dot_acc #(
  parameter int PW = 24,
  parameter int LEN = 8,
  localparam int CW = $clog2(LEN) + 1,
  localparam int SW = PW + $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [SW-1:0] sum_n;
  logic [CW-1:0] count_n;

  logic          accept;
  logic          term_end;
  logic [SW-1:0] acc_sum;
  logic [CW-1:0] cnt_inc;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  assign accept   = in_valid & in_ready;
  assign term_end = in_last | (cnt == LAST_IDX);
  assign acc_sum  = acc + SW'(in_prod);
  assign cnt_inc  = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_sum   <= sum_n;
      out_count <= count_n;
    end
  end

  // clear wins over any handshake; the result regs keep their last value
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    sum_n   = out_sum;
    count_n = out_count;
    if (clear) begin
      state_n = ACC;
      acc_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            if (term_end) begin
              sum_n   = acc_sum;
              count_n = cnt_inc;
              acc_n   = '0;
              cnt_n   = '0;
              state_n = HOLD;
            end else begin
              acc_n = acc_sum;
              cnt_n = cnt_inc;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_n = ACC;
          end
        end
        default: state_n = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mul12u_dot_acc.sv
// Scoreboard bench for mul12u_dot_acc: directed vectors, queued
// expected results, and an independent output monitor.
module tb_mul12u_dot_acc;

  localparam int PW = 24;
  localparam int LEN = 8;
  localparam int CW = 4;
  localparam int SW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prod = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SW-1:0] sum;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];

  mul12u_dot_acc #(.PW(PW), .LEN(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_prod(in_prod),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic [SW-1:0] s, input logic [CW-1:0] c);
    exp_t e;
    e.sum = s;
    e.count = c;
    exp_q.push_back(e);
  endtask

  // drive one term and return 1 time unit after the edge that took it
  task automatic send(input logic [PW-1:0] p, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_prod = p;
    in_last = l;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never rose, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: a handshake seen at the negedge completes at the next posedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: sum 0x%0h count %0d, expected none",
                   out_sum, out_count);
        end else begin
          e = exp_q.pop_front();
          if (out_sum !== e.sum || out_count !== e.count) begin
            errors++;
            $display("FAIL result: sum 0x%0h count %0d, expected 0x%0h count %0d",
                     out_sum, out_count, e.sum, e.count);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] held;
    // reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    #5;
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 8 back-to-back full vector
    expect_res(27'h500000, 4'd8);
    for (int i = 0; i < 8; i++) send(24'h0A0000, 1'b0);
    check("t1_valid_next", 32'(out_valid), 32'd1);
    check("t1_ready_low", 32'(in_ready), 32'd0);
    step();
    check("t1_ready_back", 32'(in_ready), 32'd1);
    check("t1_valid_drop", 32'(out_valid), 32'd0);

    // short vector via in_last
    expect_res(27'h0C0000, 4'd3);
    send(24'h020000, 1'b0);
    send(24'h040000, 1'b0);
    send(24'h060000, 1'b1);
    check("t2_valid", 32'(out_valid), 32'd1);
    step();

    // full scale, back-pressure held for 5 cycles
    out_ready = 1'b0;
    expect_res(27'h7FFFFF8, 4'd8);
    for (int i = 0; i < 8; i++) send(24'hFFFFFF, 1'b0);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_prod = 24'h123456;
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_ready", 32'(in_ready), 32'd0);
      check("t3_hold_sum", 32'(out_sum), 32'h7FFFFF8);
      check("t3_hold_count", 32'(out_count), 32'd8);
      step();
      check("t3_sum_stable", 32'(out_sum), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("t3_released", 32'(out_valid), 32'd0);

    // long vector wraps into 8 + 2
    expect_res(27'h100000, 4'd8);
    expect_res(27'h040000, 4'd2);
    for (int i = 0; i < 10; i++) send(24'h020000, i == 9);
    step();

    // clear aborts the partial sum and drops the coincident product
    for (int i = 0; i < 4; i++) send(24'h100000, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_prod = 24'h100000;
    in_last = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_valid", 32'(out_valid), 32'd0);
      step();
    end
    expect_res(27'h020000, 4'd1);
    send(24'h020000, 1'b1);
    step();

    // async reset mid-vector
    send(24'h300000, 1'b0);
    send(24'h300000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();
    // async reset during HOLD
    out_ready = 1'b0;
    send(24'h010000, 1'b0);
    send(24'h010000, 1'b1);
    check("t6_hold_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_hold_valid", 32'(out_valid), 32'd0);
    check("t6_rst_hold_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    expect_res(27'h040000, 4'd2);
    send(24'h030000, 1'b0);
    send(24'h010000, 1'b1);
    step();
    step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
